// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and the flag bundle shared by the ALU pipeline.
// No ports; imported by alu_core and alu_pipe.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_MOV  = 4'd0;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd4;
  localparam logic [OP_W-1:0] OP_NAND = 4'd5;
  localparam logic [OP_W-1:0] OP_AND  = 4'd6;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd7;
  localparam logic [OP_W-1:0] OP_OR   = 4'd8;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd9;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd10;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd11;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd12;
  // Encodings from here to the top of the opcode space are undefined.
  localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'd13;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result bus of the pipelined ALU.
//   Input side : in_valid, in_ready, ALUOp, R2, R3.
//   Output side: out_valid, out_ready, R1, carry, overflow, zero, negative, illegal.
//   master = operand-fetch / writeback side, slave = the ALU pipeline.
interface alu_pipe_if #(
  parameter int unsigned N = 32
) ();

  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUOp;
  logic [N-1:0] R2;
  logic [N-1:0] R3;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] R1;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic         illegal;

  modport master (
    output in_valid, ALUOp, R2, R3, out_ready,
    input  in_ready, out_valid, R1, carry, overflow, zero, negative, illegal
  );

  modport slave (
    input  in_valid, ALUOp, R2, R3, out_ready,
    output in_ready, out_valid, R1, carry, overflow, zero, negative, illegal
  );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational N-bit ALU.
//   op     : operation select (alu_pkg opcodes)
//   a, b   : operands (b[SHW-1:0] is the shift amount for shifts)
//   result : N-bit result
//   flags  : carry, overflow, zero, negative, illegal
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output alu_flags_t   flags
);

  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [SHW-1:0] shamt;
  logic           lt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    flags  = '0;

    sum  = {1'b0, a} + {1'b0, b};
    // Subtraction as a + ~b + 1 so the carry-out means "no borrow".
    diff = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    // Signed less-than that stays correct when a-b overflows: with
    // differing signs the negative operand is the smaller one.
    lt   = (a[N-1] != b[N-1]) ? a[N-1] : diff[N-1];

    case (op)
      OP_MOV:  result = a;
      OP_NOT:  result = ~a;
      OP_ADD: begin
        result         = sum[N-1:0];
        flags.carry    = sum[N];
        flags.overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_NOR:  result = ~(a | b);
      OP_SUB: begin
        result         = diff[N-1:0];
        flags.carry    = diff[N];
        flags.overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_NAND: result = ~(a & b);
      OP_AND:  result = a & b;
      OP_SLT:  result = {{(N-1){1'b0}}, lt};
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      default: flags.illegal = 1'b1;
    endcase

    flags.zero     = (result == '0);
    flags.negative = result[N-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready flow control.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : alu_pipe_if slave (operands in, result + flags out)
// s1 captures the operation on a handshake; s2 registers the alu_core
// result. Outputs come straight from the s2 registers.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);

  logic         s1_valid_q, s1_valid_d;
  logic [3:0]   s1_op_q,    s1_op_d;
  logic [N-1:0] s1_a_q,     s1_a_d;
  logic [N-1:0] s1_b_q,     s1_b_d;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] r1_q,        r1_d;
  alu_flags_t   flags_q,     flags_d;

  logic         s2_load_c;
  logic         s1_load_c;
  logic [N-1:0] core_result;
  alu_flags_t   core_flags;

  alu_core #(.N(N), .SHW(SHW)) u_core (
    .op     (s1_op_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .result (core_result),
    .flags  (core_flags)
  );

  // Advance control and next-state for both stages.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    r1_d        = r1_q;
    flags_d     = flags_q;

    s2_load_c = !out_valid_q || bus.out_ready;
    s1_load_c = !s1_valid_q || s2_load_c;

    if (s1_load_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_op_d = bus.ALUOp;
        s1_a_d  = bus.R2;
        s1_b_d  = bus.R3;
      end
    end

    if (s2_load_c) begin
      out_valid_d = s1_valid_q;
      // Data only moves on a real op; a bubble just drops out_valid.
      if (s1_valid_q) begin
        r1_d    = core_result;
        flags_d = core_flags;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      r1_q        <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      r1_q        <= r1_d;
      flags_q     <= flags_d;
    end
  end

  // in_ready depends on out_ready only, never on in_valid.
  assign bus.in_ready  = s1_load_c;
  assign bus.out_valid = out_valid_q;
  assign bus.R1        = r1_q;
  assign bus.carry     = flags_q.carry;
  assign bus.overflow  = flags_q.overflow;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;
  assign bus.illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe at N=32 plus a
// short N=8 instance sharing clock and reset.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] r1;
    logic [4:0]  fl;   // {carry, overflow, zero, negative, illegal}
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_sent = 0;
  int   n_recv = 0;
  int   n_discard = 0;
  exp_t sb[$];

  alu_pipe_if #(.N(32)) bus ();
  alu_pipe_if #(.N(8))  bus8 ();

  alu_pipe #(.N(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_pipe #(.N(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: observed timeout/unexpected expected none", tag);
  endtask

  // Reference model built from wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] u;
    longint      s;
    logic [31:0] r;
    logic        c, v, ill;
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      4'd0:  r = a;
      4'd1:  r = ~a;
      4'd2: begin
        u = 64'(a) + 64'(b);
        r = u[31:0];
        c = u[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s != longint'($signed(r)));
      end
      4'd3:  r = ~(a | b);
      4'd4: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s != longint'($signed(r)));
      end
      4'd5:  r = ~(a & b);
      4'd6:  r = a & b;
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  r = a | b;
      4'd9:  r = a ^ b;
      4'd10: r = a << b[4:0];
      4'd11: r = a >> b[4:0];
      4'd12: r = $unsigned($signed(a) >>> b[4:0]);
      default: ill = 1'b1;
    endcase
    e.op = op;
    e.r1 = r;
    e.fl = {c, v, (r == 32'd0), r[31], ill};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int  guard;
    bit  done;
    guard = 0;
    done  = 1'b0;
    bus.in_valid = 1'b1;
    bus.ALUOp    = op;
    bus.R2       = a;
    bus.R3       = b;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(op, a, b));
        n_sent++;
        done = 1'b1;
      end
      tick();
      guard++;
      if (!done && guard > 50) begin
        fail_now("send_timeout");
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_r1"}, 64'(bus.R1), 64'd0);
    check({tag, "_flags"}, 64'({bus.carry, bus.overflow, bus.zero, bus.negative, bus.illegal}), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  // One op through the N=8 instance, checked against hand-derived values.
  task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_r1, input logic [4:0] exp_fl);
    int guard;
    bit seen;
    bus8.in_valid = 1'b1;
    bus8.ALUOp    = op;
    bus8.R2       = a;
    bus8.R3       = b;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(bus8.in_ready), 64'd1);
    tick();
    bus8.in_valid = 1'b0;
    guard = 0;
    seen  = 1'b0;
    while (!seen && guard < 10) begin
      @(negedge clk);
      if (bus8.out_valid) begin
        seen = 1'b1;
        check({tag, "_r1"}, 64'(bus8.R1), 64'(exp_r1));
        check({tag, "_flags"}, 64'({bus8.carry, bus8.overflow, bus8.zero, bus8.negative, bus8.illegal}), 64'(exp_fl));
      end
      tick();
      guard++;
    end
    if (!seen) fail_now({tag, "_timeout"});
  endtask

  // Scoreboard: compare every transferred result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_recv++;
        check($sformatf("out_r1_op%0d", e.op), 64'(bus.R1), 64'(e.r1));
        check($sformatf("out_flags_op%0d", e.op),
              64'({bus.carry, bus.overflow, bus.zero, bus.negative, bus.illegal}), 64'(e.fl));
      end
    end
  end

  initial begin
    int t0;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.ALUOp      = '0;
    bus.R2         = '0;
    bus.R3         = '0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.ALUOp     = '0;
    bus8.R2        = '0;
    bus8.R3        = '0;
    bus8.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check_reset_state("reset");
    check("reset_n8_out_valid", 64'(bus8.out_valid), 64'd0);
    rst = 1'b0;

    // MOV latency and bubble
    send(OP_MOV, 32'd421, 32'd0);
    idle();
    check("mov_lat_early", 64'(bus.out_valid), 64'd0);
    tick();
    check("mov_lat_valid", 64'(bus.out_valid), 64'd1);
    check("mov_lat_r1", 64'(bus.R1), 64'd421);
    tick();
    check("bubble_out_valid", 64'(bus.out_valid), 64'd0);
    drain();

    // Back-to-back stream at full rate
    t0 = cyc;
    send(OP_NOT,  32'hAAAAAAAA, 32'd0);
    send(OP_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF);
    send(OP_ADD,  32'h7FFFFFFF, 32'd1);
    send(OP_SUB,  32'd5,        32'd12);
    send(OP_SUB,  32'd54,       32'd0);
    send(OP_SUB,  32'h80000000, 32'd1);
    send(OP_SLT,  32'h7FFFFFFF, 32'h80000001);
    send(OP_SLT,  32'hFFFFFFFE, 32'hFFFFFFFF);
    send(OP_SLT,  32'h80000000, 32'h7FFFFFFF);
    send(OP_SRA,  32'h80000000, 32'd4);
    send(OP_SLL,  32'd1,        32'd31);
    send(OP_SRL,  32'h80000000, 32'h00000023);
    send(OP_OR,   32'hF0F00000, 32'h0000F0F0);
    send(OP_XOR,  32'hAAAAAAAA, 32'hAAAAAAAA);
    send(OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send(OP_AND,  32'h12345678, 32'h0F0F0F0F);
    send(OP_NOR,  32'd0,        32'd0);
    send(OP_MOV,  32'd0,        32'd0);
    check("full_rate_cycles", 64'(cyc - t0), 64'd18);
    idle();
    drain();

    // Backpressure: stall for 5 cycles while offering 4 ops
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'd1,  32'd2);
    send(OP_SUB, 32'd10, 32'd3);
    bus.in_valid = 1'b1;
    bus.ALUOp    = OP_XOR;
    bus.R2       = 32'h0000FFFF;
    bus.R3       = 32'h00FF00FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready_%0d", i), 64'(bus.in_ready), 64'd0);
      check($sformatf("stall_out_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("stall_r1_%0d", i), 64'(bus.R1), 64'd3);
      tick();
    end
    bus.out_ready = 1'b1;
    send(OP_XOR, 32'h0000FFFF, 32'h00FF00FF);
    send(OP_SLL, 32'h00000003, 32'h00000021);
    idle();
    drain();

    // Illegal opcodes and zero flag
    send(4'd14, 32'd123, 32'd5);
    send(4'd13, 32'hFFFFFFFF, 32'd1);
    send(4'd15, 32'd7, 32'd7);
    send(OP_XOR, 32'hAAAAAAAA, 32'hAAAAAAAA);
    idle();
    drain();

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'd100, 32'd200);
    send(OP_MOV, 32'hDEADBEEF, 32'd0);
    idle();
    check("pre_reset_full", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_discard += sb.size();
    sb.delete();
    check_reset_state("midreset");
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("post_reset_no_stale", 64'(bus.out_valid), 64'd0);
    send(OP_MOV, 32'd7, 32'd0);
    idle();
    drain();

    // N=8 instance
    run8("n8_add_wrap", OP_ADD, 8'hFF, 8'h01, 8'h00, 5'b10100);
    run8("n8_sub_ovf",  OP_SUB, 8'h80, 8'h01, 8'h7F, 5'b11000);
    run8("n8_sra",      OP_SRA, 8'h90, 8'h0B, 8'hF2, 5'b00010);
    run8("n8_illegal",  4'd13,  8'h55, 8'h01, 8'h00, 5'b00101);

    // Accounting: every accepted op produced exactly one result
    check("recv_count", 64'(n_recv), 64'(n_sent - n_discard));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
